// File: rtl/thco_pkg.sv
// Shared definitions for the THCO-MIPS subset CPU: word size, reset levels,
// opcode/funct encodings and immediate sign-extension helpers.
package thco_pkg;

  localparam int WORD = 16;

  localparam logic RstEnable  = 1'b0;
  localparam logic RstDisable = 1'b1;

  typedef logic [WORD-1:0] word_t;

  localparam logic [4:0] OP_NOP    = 5'b00001;
  localparam logic [4:0] OP_ADDIU  = 5'b01001;
  localparam logic [4:0] OP_ADDIU3 = 5'b01000;
  localparam logic [4:0] OP_LI     = 5'b01101;
  localparam logic [4:0] OP_RRR    = 5'b11100;
  localparam logic [4:0] OP_MOVE   = 5'b01111;
  localparam logic [4:0] OP_SHIFT  = 5'b00110;
  localparam logic [4:0] OP_LOGIC  = 5'b11101;
  localparam logic [4:0] OP_B      = 5'b00010;
  localparam logic [4:0] OP_BEQZ   = 5'b00100;
  localparam logic [4:0] OP_BNEZ   = 5'b00101;
  localparam logic [4:0] OP_LW     = 5'b10011;
  localparam logic [4:0] OP_SW     = 5'b11011;

  localparam logic [4:0] FN_AND = 5'b01100;
  localparam logic [4:0] FN_OR  = 5'b01101;
  localparam logic [4:0] FN_CMP = 5'b01010;
  localparam logic [4:0] FN_JR  = 5'b00000;

  localparam logic [1:0] SUB_ADDU = 2'b01;
  localparam logic [1:0] SUB_SUBU = 2'b11;
  localparam logic [1:0] SH_SLL   = 2'b00;
  localparam logic [1:0] SH_SRA   = 2'b11;

  // One register-file write request produced by decode.
  typedef struct packed {
    logic       we;
    logic [2:0] addr;
    word_t      data;
  } reg_wr_t;

  function automatic word_t sext4(input logic [3:0] v);
    return {{12{v[3]}}, v};
  endfunction

  function automatic word_t sext5(input logic [4:0] v);
    return {{11{v[4]}}, v};
  endfunction

  function automatic word_t sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

  function automatic word_t sext11(input logic [10:0] v);
    return {{5{v[10]}}, v};
  endfunction

endpackage

// File: rtl/thco_regfile.sv
// 8x16 register file: two combinational read ports, one write port on the
// rising edge, asynchronous active-low clear of all registers.
module thco_regfile
  import thco_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [2:0]       waddr,
  input  logic [WORD-1:0]  wdata,
  input  logic [2:0]       raddr1,
  output logic [WORD-1:0]  rdata1,
  input  logic [2:0]       raddr2,
  output logic [WORD-1:0]  rdata2
);

  logic [WORD-1:0] regs [0:7];

  // Reads return the pre-edge value, so an instruction reading its own
  // destination sees the old contents.
  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

endmodule

// File: rtl/thco_cpu_top.sv
// Single-cycle 16-bit THCO-MIPS subset CPU with internal instruction ROM and
// data RAM; the ROM image is preloaded into irom by the integrating environment.
module thco_cpu_top
  import thco_pkg::*;
#(
  parameter int IROM_DEPTH = 256,
  parameter int DRAM_DEPTH = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_choose
);

  localparam int IA = $clog2(IROM_DEPTH);
  localparam int DA = $clog2(DRAM_DEPTH);

  word_t         pc;
  word_t         pc_next;
  word_t         pc_plus1;
  logic          t_flag;
  logic          t_next;
  logic          t_we;
  logic          tog;
  logic          en;

  word_t         inst;
  logic [4:0]    op;
  logic [2:0]    rx;
  logic [2:0]    ry;
  logic [2:0]    rz;
  word_t         rx_val;
  word_t         ry_val;
  logic [3:0]    sh;

  reg_wr_t       wr;
  logic          mem_we;
  logic [DA-1:0] mem_addr;
  word_t         mem_rdata;

  // Unprogrammed ROM words read as NOP.
  logic [WORD-1:0] irom [0:IROM_DEPTH-1] = '{default: 16'h0800};
  logic [WORD-1:0] dram [0:DRAM_DEPTH-1];

  assign en        = (rst == RstDisable) & (~clk_choose | tog);
  assign inst      = irom[pc[IA-1:0]];
  assign op        = inst[15:11];
  assign rx        = inst[10:8];
  assign ry        = inst[7:5];
  assign rz        = inst[4:2];
  assign pc_plus1  = pc + 16'd1;
  assign sh        = (inst[4:2] == 3'd0) ? 4'd8 : {1'b0, inst[4:2]};
  assign mem_addr  = DA'(rx_val + sext5(inst[4:0]));
  assign mem_rdata = dram[mem_addr];

  thco_regfile u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (wr.we & en),
    .waddr  (wr.addr),
    .wdata  (wr.data),
    .raddr1 (rx),
    .rdata1 (rx_val),
    .raddr2 (ry),
    .rdata2 (ry_val)
  );

  // Decode and execute; anything not matched below falls through as a NOP.
  always_comb begin
    pc_next = pc_plus1;
    wr      = '0;
    t_we    = 1'b0;
    t_next  = t_flag;
    mem_we  = 1'b0;
    case (op)
      OP_NOP: ;
      OP_ADDIU: wr = '{we: 1'b1, addr: rx, data: rx_val + sext8(inst[7:0])};
      OP_ADDIU3: begin
        if (!inst[4]) wr = '{we: 1'b1, addr: ry, data: rx_val + sext4(inst[3:0])};
      end
      OP_LI: wr = '{we: 1'b1, addr: rx, data: {8'h00, inst[7:0]}};
      OP_RRR: begin
        if (inst[1:0] == SUB_ADDU)      wr = '{we: 1'b1, addr: rz, data: rx_val + ry_val};
        else if (inst[1:0] == SUB_SUBU) wr = '{we: 1'b1, addr: rz, data: rx_val - ry_val};
      end
      OP_MOVE: begin
        if (inst[4:0] == 5'd0) wr = '{we: 1'b1, addr: rx, data: ry_val};
      end
      OP_SHIFT: begin
        if (inst[1:0] == SH_SLL)      wr = '{we: 1'b1, addr: rx, data: ry_val << sh};
        else if (inst[1:0] == SH_SRA) wr = '{we: 1'b1, addr: rx, data: word_t'($signed(ry_val) >>> sh)};
      end
      OP_LOGIC: begin
        case (inst[4:0])
          FN_AND: wr = '{we: 1'b1, addr: rx, data: rx_val & ry_val};
          FN_OR:  wr = '{we: 1'b1, addr: rx, data: rx_val | ry_val};
          FN_CMP: begin
            t_we   = 1'b1;
            t_next = (rx_val != ry_val);
          end
          FN_JR:  pc_next = rx_val;
          default: ;
        endcase
      end
      OP_B:    pc_next = pc_plus1 + sext11(inst[10:0]);
      OP_BEQZ: if (rx_val == '0) pc_next = pc_plus1 + sext8(inst[7:0]);
      OP_BNEZ: if (rx_val != '0) pc_next = pc_plus1 + sext8(inst[7:0]);
      OP_LW:   wr = '{we: 1'b1, addr: ry, data: mem_rdata};
      OP_SW:   mem_we = 1'b1;
      default: ;
    endcase
  end

  // In half-rate mode the toggle alternates every cycle, opening the step
  // enable on every second edge.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      pc     <= '0;
      t_flag <= 1'b0;
      tog    <= 1'b0;
    end else begin
      if (clk_choose) tog <= ~tog;
      if (en) begin
        pc <= pc_next;
        if (t_we) t_flag <= t_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en && mem_we) dram[mem_addr] <= ry_val;
  end

endmodule

// File: tb/tb_thco_cpu_top.sv
// Directed bench for thco_cpu_top: loads small programs into the ROM,
// steps the CPU and compares architectural state against hand-computed values.
module tb_thco_cpu_top;

  logic clk;
  logic rst;
  logic clk_choose;

  int checks;
  int errors;

  thco_cpu_top dut (
    .clk        (clk),
    .rst        (rst),
    .clk_choose (clk_choose)
  );

  initial clk = 1'b0;
  always #2 clk = ~clk;

  typedef struct packed {
    logic [3:0]  prog_id;
    logic [7:0]  cycles;
    logic        choose;
    logic [1:0]  kind;
    logic [7:0]  idx;
    logic [15:0] exp;
  } vec_t;

  localparam logic [1:0] K_REG  = 2'd0;
  localparam logic [1:0] K_PC   = 2'd1;
  localparam logic [1:0] K_T    = 2'd2;
  localparam logic [1:0] K_DRAM = 2'd3;

  localparam int NVEC = 26;

  logic [15:0] progs [0:15][0:15];
  vec_t        vecs  [0:NVEC-1];

  function automatic vec_t mk(input int p, input int c, input logic ch,
                              input logic [1:0] k, input int i, input logic [15:0] e);
    vec_t v;
    v.prog_id = 4'(p);
    v.cycles  = 8'(c);
    v.choose  = ch;
    v.kind    = k;
    v.idx     = 8'(i);
    v.exp     = e;
    return v;
  endfunction

  function automatic logic [15:0] probe(input logic [1:0] k, input int i);
    case (k)
      K_REG:   return dut.u_regfile.regs[i[2:0]];
      K_PC:    return dut.pc;
      K_T:     return {15'd0, dut.t_flag};
      default: return dut.dram[i[7:0]];
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  // Load a program, hold reset across an edge, release on a falling edge.
  task automatic applyStimulus(input int p, input logic ch);
    @(negedge clk);
    rst        = 1'b0;
    clk_choose = ch;
    for (int i = 0; i < 16; i++) dut.irom[i] = progs[p][i];
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b0;
    clk_choose = 1'b0;

    for (int p = 0; p < 16; p++)
      for (int i = 0; i < 16; i++) progs[p][i] = 16'h0800;

    {progs[1][0], progs[1][1], progs[1][2], progs[1][3]} = {16'h6805, 16'h6903, 16'hE029, 16'hE02F};
    {progs[2][0], progs[2][1], progs[2][2], progs[2][3]} = {16'h6810, 16'h69AB, 16'hD822, 16'h9882};
    {progs[3][0], progs[3][1], progs[3][2]} = {16'h6803, 16'h48FF, 16'h28FE};
    {progs[4][0], progs[4][1]} = {16'h0800, 16'h17FF};
    {progs[5][0], progs[5][1]} = {16'h6880, 16'h3103};
    {progs[6][0], progs[6][1], progs[6][2]} = {16'h6880, 16'h3000, 16'h3103};
    {progs[7][0], progs[7][1], progs[7][2], progs[7][3], progs[7][4]} =
      {16'h6805, 16'h6903, 16'hE82A, 16'h6905, 16'hE82A};
    {progs[8][0], progs[8][1]} = {16'h6807, 16'hFFFF};
    {progs[9][0], progs[9][1], progs[9][2], progs[9][3], progs[9][4], progs[9][5]} =
      {16'h680F, 16'h693C, 16'h7A00, 16'hE82C, 16'hEA2D, 16'h416E};
    {progs[10][0], progs[10][1], progs[10][2], progs[10][6], progs[10][9]} =
      {16'h6D06, 16'hED00, 16'h6EEE, 16'h2702, 16'h6E11};

    vecs[0]  = mk(1, 4, 1'b0, K_REG, 2, 16'h0008);
    vecs[1]  = mk(1, 4, 1'b0, K_REG, 3, 16'h0002);
    vecs[2]  = mk(1, 3, 1'b0, K_REG, 3, 16'h0000);
    vecs[3]  = mk(2, 4, 1'b0, K_DRAM, 8'h12, 16'h00AB);
    vecs[4]  = mk(2, 4, 1'b0, K_REG, 4, 16'h00AB);
    vecs[5]  = mk(3, 7, 1'b0, K_REG, 0, 16'h0000);
    vecs[6]  = mk(3, 7, 1'b0, K_PC, 0, 16'h0003);
    vecs[7]  = mk(3, 5, 1'b0, K_PC, 0, 16'h0001);
    vecs[8]  = mk(3, 5, 1'b0, K_REG, 0, 16'h0001);
    vecs[9]  = mk(4, 5, 1'b0, K_PC, 0, 16'h0001);
    vecs[10] = mk(1, 8, 1'b1, K_REG, 2, 16'h0008);
    vecs[11] = mk(1, 8, 1'b1, K_REG, 3, 16'h0002);
    vecs[12] = mk(1, 7, 1'b1, K_REG, 3, 16'h0000);
    vecs[13] = mk(5, 2, 1'b0, K_REG, 1, 16'h0000);
    vecs[14] = mk(6, 3, 1'b0, K_REG, 0, 16'h8000);
    vecs[15] = mk(6, 3, 1'b0, K_REG, 1, 16'hFF80);
    vecs[16] = mk(7, 3, 1'b0, K_T, 0, 16'h0001);
    vecs[17] = mk(7, 5, 1'b0, K_T, 0, 16'h0000);
    vecs[18] = mk(8, 2, 1'b0, K_PC, 0, 16'h0002);
    vecs[19] = mk(8, 2, 1'b0, K_REG, 0, 16'h0007);
    vecs[20] = mk(9, 6, 1'b0, K_REG, 0, 16'h000C);
    vecs[21] = mk(9, 6, 1'b0, K_REG, 2, 16'h003F);
    vecs[22] = mk(9, 6, 1'b0, K_REG, 3, 16'h003A);
    vecs[23] = mk(10, 4, 1'b0, K_PC, 0, 16'h000A);
    vecs[24] = mk(10, 4, 1'b0, K_REG, 6, 16'h0011);
    vecs[25] = mk(10, 3, 1'b0, K_REG, 6, 16'h0000);

    // Power-on reset: PC and state held at zero across edges, then counting.
    #1;
    for (int i = 0; i < 16; i++) dut.irom[i] = progs[0][i];
    checkOutput("reset_pc", dut.pc, 16'h0000);
    repeat (2) @(negedge clk);
    checkOutput("reset_pc_held", dut.pc, 16'h0000);
    checkOutput("reset_t", {15'd0, dut.t_flag}, 16'h0000);
    checkOutput("reset_r7", dut.u_regfile.regs[7], 16'h0000);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("nop_pc_count", dut.pc, 16'h0003);

    for (int v = 0; v < NVEC; v++) begin
      applyStimulus(int'(vecs[v].prog_id), vecs[v].choose);
      repeat (int'(vecs[v].cycles)) @(negedge clk);
      checkOutput($sformatf("vec%0d", v), probe(vecs[v].kind, int'(vecs[v].idx)), vecs[v].exp);
    end

    // Asynchronous reset pulse in the middle of a program.
    applyStimulus(1, 1'b0);
    repeat (4) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("midrst_r2", dut.u_regfile.regs[2], 16'h0000);
    checkOutput("midrst_pc", dut.pc, 16'h0000);
    @(negedge clk);
    checkOutput("midrst_pc_held", dut.pc, 16'h0000);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_restart_pc", dut.pc, 16'h0001);
    checkOutput("midrst_restart_r0", dut.u_regfile.regs[0], 16'h0005);
    checkOutput("midrst_restart_r1", dut.u_regfile.regs[1], 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
